sata_oob_ctrl: RTL and testbench



---
 rtl/sata_oob_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sata_oob_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB / link-initialisation sequencer.
// Drives the burst/idle transmitter through COMRESET, COMWAKE, D10.2, ALIGNp and
// SYNCp phases. It reacts to the squelch strobes and the primitive-detect flags
// from the receive path, reports link-up, and retries from COMRESET after any
// timeout.
// Optional build macro SATA_OOB_HOTPLUG_EN: while the link is up, i_rx_elecidle
// held for HOTPLUG_CLKS consecutive clocks drops the link and re-runs COMRESET.
module sata_oob_ctrl #(
  parameter int BURST_CLKS      = 160,
  parameter int RESET_IDLE_CLKS = 480,
  parameter int WAKE_IDLE_CLKS  = 160,
  parameter int N_BURSTS        = 6,
  parameter int RESP_TIMEOUT    = 65535,
  parameter int ALIGN_TIMEOUT   = 32767,
  parameter int HOTPLUG_CLKS    = 4095
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_cominit_det,
  input  logic       i_comwake_det,
  input  logic       i_rx_align,
  input  logic       i_rx_nonalign,
  input  logic       i_rx_elecidle,
  output logic       o_tx_burst,
  output logic [1:0] o_tx_prim,
  output logic       o_link_up,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [7:0] o_retry_cnt
);

  // The phase counter must hold the longest burst or idle segment.
  localparam int PH_MAX0 = (BURST_CLKS > RESET_IDLE_CLKS) ? BURST_CLKS : RESET_IDLE_CLKS;
  localparam int PH_MAX  = (PH_MAX0 > WAKE_IDLE_CLKS) ? PH_MAX0 : WAKE_IDLE_CLKS;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int BC_W    = $clog2(N_BURSTS) + 1;
  localparam int TO_MAX  = (RESP_TIMEOUT > ALIGN_TIMEOUT) ? RESP_TIMEOUT : ALIGN_TIMEOUT;
  localparam int TO_W    = $clog2(TO_MAX + 1);

  localparam logic [PH_W-1:0] BURST_LAST      = PH_W'(BURST_CLKS - 1);
  localparam logic [PH_W-1:0] RESET_IDLE_LAST = PH_W'(RESET_IDLE_CLKS - 1);
  localparam logic [PH_W-1:0] WAKE_IDLE_LAST  = PH_W'(WAKE_IDLE_CLKS - 1);
  localparam logic [BC_W-1:0] BURST_N_LAST    = BC_W'(N_BURSTS - 1);
  localparam logic [TO_W-1:0] RESP_LAST       = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [TO_W-1:0] ALIGN_LAST      = TO_W'(ALIGN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMRESET,
    ST_WAIT_COMINIT,
    ST_COMWAKE,
    ST_WAIT_COMWAKE,
    ST_SEND_D10,
    ST_SEND_ALIGN,
    ST_READY
  } state_t;

  state_t          state_reg, state_next;
  logic [PH_W-1:0] phase_reg, phase_next;
  logic            idle_reg, idle_next;        // 0: burst segment, 1: idle segment
  logic [BC_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [TO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic            timeout_reg, timeout_next;
  logic [7:0]      retry_reg, retry_next;

  logic [PH_W-1:0] seg_last;
  logic [TO_W-1:0] tmo_limit;
  logic            tmo_hit;
  logic            tmo_expired;
  logic            tmo_counting;

`ifdef SATA_OOB_HOTPLUG_EN
  localparam int              HP_W    = $clog2(HOTPLUG_CLKS + 1);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(HOTPLUG_CLKS - 1);
  logic [HP_W-1:0] hp_cnt_reg, hp_cnt_next;
  logic            hp_drop;

  // Electrical-idle run length, counted only while the link is up.
  always_ff @(posedge i_clk) begin
    if (i_rst) hp_cnt_reg <= '0;
    else       hp_cnt_reg <= hp_cnt_next;
  end

  // Run length continues only while staying in READY with squelch idle.
  always_comb begin
    hp_cnt_next = '0;
    if (state_reg == ST_READY && state_next == ST_READY && i_rx_elecidle)
      hp_cnt_next = hp_cnt_reg + HP_W'(1);
  end

  assign hp_drop = i_rx_elecidle && (hp_cnt_reg == HP_LAST);
`else
  // Hot-plug detection is not built; the input is deliberately left unused.
  logic unused_hotplug;
  assign unused_hotplug = i_rx_elecidle ^ (HOTPLUG_CLKS != 0);
`endif

  // State and counter registers; reset returns everything to idle at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      idle_reg      <= 1'b0;
      burst_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      timeout_reg   <= 1'b0;
      retry_reg     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      idle_reg      <= idle_next;
      burst_cnt_reg <= burst_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      timeout_reg   <= timeout_next;
      retry_reg     <= retry_next;
    end
  end

  // Next-state logic: burst/idle sequencing, handshake progress and timeouts.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    idle_next      = idle_reg;
    burst_cnt_next = burst_cnt_reg;
    tmo_cnt_next   = '0;
    timeout_next   = 1'b0;
    retry_next     = retry_reg;
    tmo_expired    = 1'b0;

    if (!idle_reg)                    seg_last = BURST_LAST;
    else if (state_reg == ST_COMWAKE) seg_last = WAKE_IDLE_LAST;
    else                              seg_last = RESET_IDLE_LAST;

    tmo_limit = (state_reg == ST_WAIT_COMINIT || state_reg == ST_WAIT_COMWAKE)
                ? RESP_LAST : ALIGN_LAST;
    tmo_hit   = (tmo_cnt_reg == tmo_limit);
    tmo_counting = (state_reg == ST_WAIT_COMINIT) || (state_reg == ST_WAIT_COMWAKE) ||
                   (state_reg == ST_SEND_D10)     || (state_reg == ST_SEND_ALIGN);

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_COMRESET;
          retry_next = 8'd0;
        end
      end
      ST_COMRESET, ST_COMWAKE: begin
        if (phase_reg == seg_last) begin
          phase_next = '0;
          if (!idle_reg) begin
            idle_next = 1'b1;
          end else begin
            idle_next = 1'b0;
            if (burst_cnt_reg == BURST_N_LAST)
              state_next = (state_reg == ST_COMRESET) ? ST_WAIT_COMINIT : ST_WAIT_COMWAKE;
            else
              burst_cnt_next = burst_cnt_reg + BC_W'(1);
          end
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      ST_WAIT_COMINIT: begin
        if (i_cominit_det) state_next = ST_COMWAKE;
        else if (tmo_hit)  tmo_expired = 1'b1;
      end
      ST_WAIT_COMWAKE: begin
        if (i_comwake_det) state_next = ST_SEND_D10;
        else if (tmo_hit)  tmo_expired = 1'b1;
      end
      ST_SEND_D10: begin
        if (i_rx_align)   state_next = ST_SEND_ALIGN;
        else if (tmo_hit) tmo_expired = 1'b1;
      end
      ST_SEND_ALIGN: begin
        if (i_rx_nonalign) state_next = ST_READY;
        else if (tmo_hit)  tmo_expired = 1'b1;
      end
      ST_READY: begin
        if (i_start) begin
          state_next = ST_COMRESET;
          retry_next = 8'd0;
        end else if (i_cominit_det) begin
          state_next = ST_COMWAKE;
`ifdef SATA_OOB_HOTPLUG_EN
        end else if (hp_drop) begin
          state_next = ST_COMRESET;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Any timeout restarts the whole sequence from COMRESET.
    if (tmo_expired) begin
      state_next   = ST_COMRESET;
      timeout_next = 1'b1;
      retry_next   = (retry_reg == 8'hFF) ? retry_reg : retry_reg + 8'd1;
    end

    // Every state entry starts with fresh counters.
    if (state_next != state_reg) begin
      phase_next     = '0;
      idle_next      = 1'b0;
      burst_cnt_next = '0;
    end else if (tmo_counting) begin
      tmo_cnt_next = tmo_cnt_reg + TO_W'(1);
    end
  end

  // Outputs decode directly from registered state.
  assign o_tx_burst  = (((state_reg == ST_COMRESET) || (state_reg == ST_COMWAKE)) && !idle_reg) ||
                       (state_reg == ST_SEND_D10) || (state_reg == ST_SEND_ALIGN) ||
                       (state_reg == ST_READY);
  assign o_tx_prim   = (state_reg == ST_SEND_ALIGN) ? 2'd1 :
                       (state_reg == ST_READY)      ? 2'd2 : 2'd0;
  assign o_link_up   = (state_reg == ST_READY);
  assign o_busy      = (state_reg != ST_IDLE) && (state_reg != ST_READY);
  assign o_timeout   = timeout_reg;
  assign o_retry_cnt = retry_reg;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Self-checking bench for sata_oob_ctrl: a time-in-phase reference model is
// compared against the DUT every cycle, and hand-computed pins fix key timings.
module tb_sata_oob_ctrl;
  localparam int B  = 4;
  localparam int RI = 12;
  localparam int WI = 4;
  localparam int NB = 6;
  localparam int RT = 50;
  localparam int AT = 40;
  localparam int HP = 100;

  localparam int P_IDLE = 0, P_CR = 1, P_WCI = 2, P_CW = 3, P_WCW = 4,
                 P_D10 = 5, P_AL = 6, P_RDY = 7;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_cominit_det = 1'b0;
  logic       i_comwake_det = 1'b0;
  logic       i_rx_align = 1'b0;
  logic       i_rx_nonalign = 1'b0;
  logic       i_rx_elecidle = 1'b0;
  logic       o_tx_burst;
  logic [1:0] o_tx_prim;
  logic       o_link_up;
  logic       o_busy;
  logic       o_timeout;
  logic [7:0] o_retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: current phase, clocks spent in it, retry count, pulse.
  int m_ph = P_IDLE;
  int m_t = 0;
  int m_retry = 0;
  int m_hp = 0;
  bit m_tmo = 1'b0;

  sata_oob_ctrl #(
    .BURST_CLKS(B), .RESET_IDLE_CLKS(RI), .WAKE_IDLE_CLKS(WI), .N_BURSTS(NB),
    .RESP_TIMEOUT(RT), .ALIGN_TIMEOUT(AT), .HOTPLUG_CLKS(HP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_cominit_det(i_cominit_det), .i_comwake_det(i_comwake_det),
    .i_rx_align(i_rx_align), .i_rx_nonalign(i_rx_nonalign),
    .i_rx_elecidle(i_rx_elecidle),
    .o_tx_burst(o_tx_burst), .o_tx_prim(o_tx_prim), .o_link_up(o_link_up),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_retry_cnt(o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic int exp_burst();
    if (m_ph == P_CR) return ((m_t % (B + RI)) < B) ? 1 : 0;
    if (m_ph == P_CW) return ((m_t % (B + WI)) < B) ? 1 : 0;
    if (m_ph == P_D10 || m_ph == P_AL || m_ph == P_RDY) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int  nph;
    bit  tmo;
    nph = m_ph;
    tmo = 1'b0;
    if (i_rst) begin
      m_ph = P_IDLE; m_t = 0; m_retry = 0; m_hp = 0; m_tmo = 1'b0;
      return;
    end
    case (m_ph)
      P_IDLE: if (i_start) begin nph = P_CR; m_retry = 0; end
      P_CR:   if (m_t + 1 == NB * (B + RI)) nph = P_WCI;
      P_WCI:  if (i_cominit_det) nph = P_CW;  else if (m_t + 1 == RT) tmo = 1'b1;
      P_CW:   if (m_t + 1 == NB * (B + WI)) nph = P_WCW;
      P_WCW:  if (i_comwake_det) nph = P_D10; else if (m_t + 1 == RT) tmo = 1'b1;
      P_D10:  if (i_rx_align) nph = P_AL;     else if (m_t + 1 == AT) tmo = 1'b1;
      P_AL:   if (i_rx_nonalign) nph = P_RDY; else if (m_t + 1 == AT) tmo = 1'b1;
      default: begin
        if (i_start) begin nph = P_CR; m_retry = 0; end
        else if (i_cominit_det) nph = P_CW;
`ifdef SATA_OOB_HOTPLUG_EN
        else if (i_rx_elecidle && m_hp + 1 == HP) nph = P_CR;
`endif
      end
    endcase
    if (tmo) begin
      nph = P_CR;
      if (m_retry < 255) m_retry = m_retry + 1;
    end
    m_tmo = tmo;
    if (m_ph == P_RDY && nph == P_RDY && i_rx_elecidle) m_hp = m_hp + 1;
    else m_hp = 0;
    m_t = (nph != m_ph) ? 0 : m_t + 1;
    m_ph = nph;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("tx_burst", int'(o_tx_burst), exp_burst());
    chk("tx_prim", int'(o_tx_prim), (m_ph == P_AL) ? 1 : (m_ph == P_RDY) ? 2 : 0);
    chk("link_up", int'(o_link_up), (m_ph == P_RDY) ? 1 : 0);
    chk("busy", int'(o_busy), (m_ph != P_IDLE && m_ph != P_RDY) ? 1 : 0);
    chk("timeout", int'(o_timeout), int'(m_tmo));
    chk("retry_cnt", int'(o_retry_cnt), m_retry);
  endtask

  // One clock: model follows the same sampled inputs, then outputs are checked.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    compare_all();
    cyc++;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  // Walk the handshake to READY, answering whatever the model is waiting for.
  task automatic go_ready();
    int n;
    n = 0;
    while (m_ph != P_RDY && n < 3000) begin
      i_start       = (m_ph == P_IDLE);
      i_cominit_det = (m_ph == P_WCI);
      i_comwake_det = (m_ph == P_WCW);
      i_rx_align    = (m_ph == P_D10);
      i_rx_nonalign = (m_ph == P_AL);
      tick();
      n++;
    end
    i_start = 1'b0; i_cominit_det = 1'b0; i_comwake_det = 1'b0;
    i_rx_align = 1'b0; i_rx_nonalign = 1'b0;
    if (m_ph != P_RDY) begin
      errors++;
      $display("FAIL go_ready cycle %0d: no READY within bound", cyc);
    end
  endtask

  task automatic wait_phase(input int ph, input int bound);
    int n;
    n = 0;
    while (m_ph != ph && n < bound) begin tick(); n++; end
    if (m_ph != ph) begin
      errors++;
      $display("FAIL wait_phase cycle %0d: phase %0d not reached", cyc, ph);
    end
  endtask

  int bursts[0:96];
  int sum;
  int pulses;
  int n;
  int busy96;

  initial begin
    // Reset state
    i_rst = 1'b1;
    repeat (3) tick();
    chk("pin_reset_burst", int'(o_tx_burst), 0);
    chk("pin_reset_busy", int'(o_busy), 0);
    chk("pin_reset_retry", int'(o_retry_cnt), 0);
    i_rst = 1'b0;
    repeat (7) tick();

    // COMRESET burst pattern from a start pulse
    pulse_start();
    bursts[0] = int'(o_tx_burst);
    for (int k = 1; k <= 96; k++) begin tick(); bursts[k] = int'(o_tx_burst); end
    busy96 = int'(o_busy);
    sum = 0;
    for (int k = 0; k < 96; k++) sum += bursts[k];
    chk("pin_burst_k0", bursts[0], 1);
    chk("pin_burst_k3", bursts[3], 1);
    chk("pin_burst_k4", bursts[4], 0);
    chk("pin_burst_k15", bursts[15], 0);
    chk("pin_burst_k16", bursts[16], 1);
    chk("pin_burst_k80", bursts[80], 1);
    chk("pin_burst_k84", bursts[84], 0);
    chk("pin_burst_total", sum, 24);
    chk("pin_wait_cominit_burst", bursts[96], 0);
    chk("pin_wait_cominit_busy", busy96, 1);
    $display("comreset sequence done at cycle %0d", cyc);

    // Full handshake
    repeat (4) tick();
    i_cominit_det = 1'b1; tick(); i_cominit_det = 1'b0;
    wait_phase(P_WCW, 200);
    i_comwake_det = 1'b1; tick(); i_comwake_det = 1'b0;
    chk("pin_d10_prim", int'(o_tx_prim), 0);
    chk("pin_d10_burst", int'(o_tx_burst), 1);
    repeat (19) tick();
    i_rx_align = 1'b1; tick(); i_rx_align = 1'b0;
    chk("pin_align_prim", int'(o_tx_prim), 1);
    repeat (7) tick();
    i_rx_nonalign = 1'b1; tick(); i_rx_nonalign = 1'b0;
    chk("pin_ready_link", int'(o_link_up), 1);
    chk("pin_ready_prim", int'(o_tx_prim), 2);
    chk("pin_ready_busy", int'(o_busy), 0);
    $display("handshake reached link-up at cycle %0d", cyc);

    // Device-initiated COMINIT while up
    i_cominit_det = 1'b1; tick(); i_cominit_det = 1'b0;
    chk("pin_devreset_link", int'(o_link_up), 0);
    chk("pin_devreset_burst", int'(o_tx_burst), 1);
    chk("pin_devreset_busy", int'(o_busy), 1);
    go_ready();

    // Start beats simultaneous COMINIT: COMRESET timing (period 16, not 8)
    i_start = 1'b1; i_cominit_det = 1'b1; tick();
    i_start = 1'b0; i_cominit_det = 1'b0;
    bursts[0] = int'(o_tx_burst);
    for (int k = 1; k <= 16; k++) begin tick(); bursts[k] = int'(o_tx_burst); end
    chk("pin_restart_k0", bursts[0], 1);
    chk("pin_restart_k3", bursts[3], 1);
    chk("pin_restart_k8", bursts[8], 0);
    chk("pin_restart_k16", bursts[16], 1);
    $display("restart over cominit checked at cycle %0d", cyc);

    // Response timeout: one pulse, one retry, bursts resume
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (o_timeout) begin
        pulses++;
        chk("pin_burst_after_timeout", int'(o_tx_burst), 1);
      end
    end
    chk("pin_timeout_pulses", pulses, 1);
    chk("pin_retry_one", int'(o_retry_cnt), 1);

    // Retry saturation
    n = 0;
    while (pulses < 257 && n < 45000) begin
      tick();
      if (o_timeout) pulses++;
      n++;
    end
    chk("pin_timeout_count_257", pulses, 257);
    chk("pin_retry_saturated", int'(o_retry_cnt), 255);
    $display("retry saturation checked at cycle %0d", cyc);

    // Reset in the third COMRESET burst
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("pin_rst_retry", int'(o_retry_cnt), 0);
    tick();
    pulse_start();
    repeat (33) tick();
    chk("pin_third_burst", int'(o_tx_burst), 1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("pin_midrst_burst", int'(o_tx_burst), 0);
    chk("pin_midrst_busy", int'(o_busy), 0);
    repeat (3) tick();
    pulse_start();
    sum = int'(o_tx_burst);
    for (int k = 1; k < 96; k++) begin tick(); sum += int'(o_tx_burst); end
    tick();
    chk("pin_rerun_total", sum, 24);
    chk("pin_rerun_wait_busy", int'(o_busy), 1);
    $display("mid-sequence reset checked at cycle %0d", cyc);

    // Randomized traffic against the model
    for (int k = 0; k < 20000; k++) begin
      i_rst         = ($urandom_range(0, 2999) == 0);
      i_start       = ($urandom_range(0, 299) == 0);
      i_cominit_det = ($urandom_range(0, 39) == 0);
      i_comwake_det = ($urandom_range(0, 19) == 0);
      i_rx_align    = ($urandom_range(0, 9) == 0);
      i_rx_nonalign = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) i_rx_elecidle = ~i_rx_elecidle;
      tick();
    end
    i_rst = 1'b0; i_start = 1'b0; i_cominit_det = 1'b0; i_comwake_det = 1'b0;
    i_rx_align = 1'b0; i_rx_nonalign = 1'b0; i_rx_elecidle = 1'b0;
    tick();
    $display("random traffic done at cycle %0d", cyc);

    // Electrical idle while the link is up
    go_ready();
`ifdef SATA_OOB_HOTPLUG_EN
    i_rx_elecidle = 1'b1;
    repeat (99) tick();
    chk("pin_hp_99_link", int'(o_link_up), 1);
    i_rx_elecidle = 1'b0; tick();
    i_rx_elecidle = 1'b1;
    repeat (100) tick();
    i_rx_elecidle = 1'b0;
    chk("pin_hp_100_link", int'(o_link_up), 0);
    chk("pin_hp_100_busy", int'(o_busy), 1);
    chk("pin_hp_100_timeout", int'(o_timeout), 0);
`else
    i_rx_elecidle = 1'b1;
    repeat (1000) tick();
    i_rx_elecidle = 1'b0;
    chk("pin_elecidle_ignored", int'(o_link_up), 1);
`endif
    $display("electrical idle check done at cycle %0d", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
